fifo_shadow_checker: RTL and testbench

//   Synthesizable, parametrised self-checking monitor for the synchronous FIFO.

---
 rtl/fifo_shadow_checker.sv | 147 ++++++++++++++
 tb/tb_fifo_shadow_checker.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_shadow_checker.sv
// rtl/fifo_shadow_checker.sv - passive shadow-model checker for a synchronous FIFO
module fifo_shadow_checker #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_LEVEL   = FIFO_DEPTH - 1,
    parameter int AE_LEVEL   = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  chk_en,
    input  logic                  mon_rst_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] data_out,
    input  logic                  wr_ack,
    input  logic                  overflow,
    input  logic                  underflow,
    input  logic                  full,
    input  logic                  almostfull,
    input  logic                  empty,
    input  logic                  almostempty,
    output logic                  err_valid,
    output logic [7:0]            err_code,
    output logic [7:0]            err_sticky,
    output logic [CNT_WIDTH-1:0]  correct_cnt,
    output logic [CNT_WIDTH-1:0]  error_cnt
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AF_C     = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C     = CW'(AE_LEVEL);
    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

    logic [DATA_WIDTH-1:0] shadow [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         occ;
    logic [DATA_WIDTH-1:0] exp_data;
    logic                  exp_wr_ack;
    logic                  exp_overflow;
    logic                  exp_underflow;
    logic                  dchk;
    logic                  armed;

    logic                  do_wr;
    logic                  do_rd;
    logic                  check_now;
    logic [7:0]            mismatch;

    // Accepted operations for this edge and the per-signal mismatch bitmap.
    always_comb begin
        do_wr       = wr_en && (occ < DEPTH_C);
        do_rd       = rd_en && (occ != '0);
        check_now   = armed && chk_en && mon_rst_n;
        mismatch    = '0;
        mismatch[0] = dchk && (data_out != exp_data);
        mismatch[1] = (wr_ack != exp_wr_ack);
        mismatch[2] = (overflow != exp_overflow);
        mismatch[3] = (underflow != exp_underflow);
        mismatch[4] = (full != (occ == DEPTH_C));
        mismatch[5] = (almostfull != (occ == AF_C));
        mismatch[6] = (empty != (occ == '0));
        mismatch[7] = (almostempty != (occ == AE_C));
    end

    // Shadow storage: only accepted writes land; contents need no reset.
    always_ff @(posedge clk) begin
        if (rst_n && mon_rst_n && do_wr) begin
            shadow[wr_ptr] <= data_in;
        end
    end

    // Predict the FIFO's next registered outputs and track occupancy/pointers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            occ           <= '0;
            exp_data      <= '0;
            exp_wr_ack    <= 1'b0;
            exp_overflow  <= 1'b0;
            exp_underflow <= 1'b0;
            dchk          <= 1'b0;
            armed         <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (!mon_rst_n) begin
                wr_ptr        <= '0;
                rd_ptr        <= '0;
                occ           <= '0;
                exp_wr_ack    <= 1'b0;
                exp_overflow  <= 1'b0;
                exp_underflow <= 1'b0;
                dchk          <= 1'b0;
            end else begin
                if (do_wr) begin
                    wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
                end
                if (do_rd) begin
                    exp_data <= shadow[rd_ptr];
                    rd_ptr   <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
                end
                case ({do_wr, do_rd})
                    2'b10:   occ <= occ + CW'(1);
                    2'b01:   occ <= occ - CW'(1);
                    default: occ <= occ;
                endcase
                exp_wr_ack    <= do_wr;
                exp_overflow  <= wr_en && !do_wr;
                exp_underflow <= rd_en && !do_rd;
                dchk          <= do_rd;
            end
        end
    end

    // Register the check result and keep saturating pass/fail tallies.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_valid   <= 1'b0;
            err_code    <= '0;
            err_sticky  <= '0;
            correct_cnt <= '0;
            error_cnt   <= '0;
        end else if (check_now) begin
            err_valid  <= |mismatch;
            err_code   <= mismatch;
            err_sticky <= err_sticky | mismatch;
            if (|mismatch) begin
                if (error_cnt != '1) begin
                    error_cnt <= error_cnt + CNT_WIDTH'(1);
                end
            end else begin
                if (correct_cnt != '1) begin
                    correct_cnt <= correct_cnt + CNT_WIDTH'(1);
                end
            end
        end else begin
            err_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_shadow_checker.sv
// tb/tb_fifo_shadow_checker.sv - directed vector bench for fifo_shadow_checker
module tb_fifo_shadow_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        chk_en;
    logic        mon_rst_n;
    logic        wr_en;
    logic        rd_en;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        wr_ack;
    logic        overflow;
    logic        underflow;
    logic        full;
    logic        almostfull;
    logic        empty;
    logic        almostempty;

    logic        err_valid;
    logic [7:0]  err_code;
    logic [7:0]  err_sticky;
    logic [15:0] correct_cnt;
    logic [15:0] error_cnt;

    logic        err_valid4;
    logic [7:0]  err_code4;
    logic [7:0]  err_sticky4;
    logic [3:0]  correct_cnt4;
    logic [3:0]  error_cnt4;

    always #5 clk = ~clk;

    fifo_shadow_checker dut (
        .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .mon_rst_n(mon_rst_n),
        .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in), .data_out(data_out),
        .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow),
        .full(full), .almostfull(almostfull), .empty(empty), .almostempty(almostempty),
        .err_valid(err_valid), .err_code(err_code), .err_sticky(err_sticky),
        .correct_cnt(correct_cnt), .error_cnt(error_cnt)
    );

    fifo_shadow_checker #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .mon_rst_n(mon_rst_n),
        .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in), .data_out(data_out),
        .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow),
        .full(full), .almostfull(almostfull), .empty(empty), .almostempty(almostempty),
        .err_valid(err_valid4), .err_code(err_code4), .err_sticky(err_sticky4),
        .correct_cnt(correct_cnt4), .error_cnt(error_cnt4)
    );

    typedef struct {
        logic        mrst;
        logic        cen;
        logic        wr;
        logic        rd;
        logic [15:0] din;
        logic [7:0]  inj;
        logic        chk;
        logic [7:0]  code;
    } vec_t;

    vec_t vecs[$];

    int n_cmp  = 0;
    int n_fail = 0;

    // Ideal 8-deep FIFO that drives the observed pins.
    logic [15:0] m_mem [8];
    int          m_wp, m_rp, m_c;
    logic [15:0] m_dout;
    logic        m_ack, m_ovf, m_udf;

    // Expected checker state.
    int          exp_ok  = 0;
    int          exp_err = 0;
    logic [7:0]  exp_code_hold = 8'h00;
    logic [7:0]  exp_sticky    = 8'h00;

    task automatic cmp(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h want %0h", name, idx, act, req);
        end
    endtask

    task automatic addv(input logic mrst, input logic cen, input logic wr, input logic rd,
                        input logic [15:0] din, input logic [7:0] inj,
                        input logic chk, input logic [7:0] code);
        vec_t v;
        v.mrst = mrst; v.cen = cen; v.wr = wr; v.rd = rd;
        v.din = din; v.inj = inj; v.chk = chk; v.code = code;
        vecs.push_back(v);
    endtask

    task automatic drive_pins(input logic [7:0] inj);
        data_out    = m_dout ^ {15'b0, inj[0]};
        wr_ack      = m_ack ^ inj[1];
        overflow    = m_ovf ^ inj[2];
        underflow   = m_udf ^ inj[3];
        full        = (m_c == 8) ^ inj[4];
        almostfull  = (m_c == 7) ^ inj[5];
        empty       = (m_c == 0) ^ inj[6];
        almostempty = (m_c == 1) ^ inj[7];
    endtask

    task automatic model_update(input logic mrst, input logic wr, input logic rd, input logic [15:0] din);
        logic dw, dr;
        if (!mrst) begin
            m_c = 0; m_wp = 0; m_rp = 0;
            m_ack = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
        end else begin
            dw = wr && (m_c < 8);
            dr = rd && (m_c > 0);
            if (dw) begin
                m_mem[m_wp] = din;
                m_wp = (m_wp + 1) % 8;
            end
            if (dr) begin
                m_dout = m_mem[m_rp];
                m_rp = (m_rp + 1) % 8;
            end
            m_c   = m_c + int'(dw) - int'(dr);
            m_ack = dw;
            m_ovf = wr && !dw;
            m_udf = rd && !dr;
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic ev;
        mon_rst_n = v.mrst;
        chk_en    = v.cen;
        wr_en     = v.wr;
        rd_en     = v.rd;
        data_in   = v.din;
        drive_pins(v.inj);
        @(posedge clk);
        #1;
        model_update(v.mrst, v.wr, v.rd, v.din);
        ev = 1'b0;
        if (v.chk) begin
            ev            = (v.code != 8'h00);
            exp_code_hold = v.code;
            exp_sticky    = exp_sticky | v.code;
            if (ev) exp_err++;
            else    exp_ok++;
        end
        cmp("err_valid",   idx, {31'b0, err_valid}, {31'b0, ev});
        cmp("err_code",    idx, {24'b0, err_code},  {24'b0, exp_code_hold});
        cmp("err_sticky",  idx, {24'b0, err_sticky}, {24'b0, exp_sticky});
        cmp("correct_cnt", idx, {16'b0, correct_cnt}, exp_ok);
        cmp("error_cnt",   idx, {16'b0, error_cnt},   exp_err);
    endtask

    initial begin
        vec_t v;
        m_wp = 0; m_rp = 0; m_c = 0;
        m_dout = 16'h0000; m_ack = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
        for (int i = 0; i < 8; i++) m_mem[i] = 16'h0000;

        rst_n = 1'b0; chk_en = 1'b1; mon_rst_n = 1'b1;
        wr_en = 1'b0; rd_en = 1'b0; data_in = 16'h0000;
        drive_pins(8'h00);

        // mrst cen wr rd din inj chk code
        addv(1, 1, 1, 0, 16'hA000, 8'h00, 0, 8'h00);              // 0: first edge, not armed
        for (int i = 1; i < 8; i++)
            addv(1, 1, 1, 0, 16'hA000 + 16'(i), 8'h00, 1, 8'h00);  // 1-7: fill to 8
        addv(1, 1, 1, 0, 16'hA008, 8'h00, 1, 8'h00);              // 8: write while full
        addv(1, 1, 0, 0, 16'h0000, 8'h04, 1, 8'h04);              // 9: overflow driven 0
        addv(1, 1, 1, 1, 16'hA009, 8'h00, 1, 8'h00);              // 10: wr+rd at 8 -> read only
        addv(1, 1, 0, 0, 16'h0000, 8'h00, 1, 8'h00);              // 11: data A+0, almostfull
        for (int i = 0; i < 3; i++)
            addv(1, 1, 0, 1, 16'h0000, 8'h00, 1, 8'h00);          // 12-14: drain to 4
        for (int i = 0; i < 5; i++)
            addv(1, 1, 1, 1, 16'hB000 + 16'(i), 8'h00, 1, 8'h00);  // 15-19: wr+rd at 4, wrap
        addv(1, 1, 0, 1, 16'h0000, 8'h01, 1, 8'h01);              // 20: corrupted data_out
        for (int i = 0; i < 3; i++)
            addv(1, 1, 0, 1, 16'h0000, 8'h00, 1, 8'h00);          // 21-23: drain to 0
        addv(1, 1, 0, 1, 16'h0000, 8'h00, 1, 8'h00);              // 24: read while empty
        addv(1, 1, 1, 1, 16'hC0DE, 8'h00, 1, 8'h00);              // 25: wr+rd on empty -> write
        addv(1, 1, 0, 0, 16'h0000, 8'h00, 1, 8'h00);              // 26: c=1 almostempty
        addv(0, 1, 0, 0, 16'h0000, 8'h00, 0, 8'h00);              // 27: FIFO reset, no check
        addv(1, 1, 0, 0, 16'h0000, 8'h01, 1, 8'h00);              // 28: empty, data not checked
        addv(1, 0, 1, 0, 16'hD00D, 8'h10, 0, 8'h00);              // 29: chk_en=0, shadow tracks
        addv(1, 1, 0, 0, 16'h0000, 8'h00, 1, 8'h00);              // 30: c=1
        addv(1, 1, 0, 1, 16'h0000, 8'h00, 1, 8'h00);              // 31: read D00D
        addv(1, 1, 0, 0, 16'h0000, 8'h00, 1, 8'h00);              // 32: data check D00D

        repeat (2) @(posedge clk);
        #1;
        cmp("rst err_valid",   -1, {31'b0, err_valid}, 32'h0);
        cmp("rst err_code",    -1, {24'b0, err_code}, 32'h0);
        cmp("rst err_sticky",  -1, {24'b0, err_sticky}, 32'h0);
        cmp("rst correct_cnt", -1, {16'b0, correct_cnt}, 32'h0);
        cmp("rst error_cnt",   -1, {16'b0, error_cnt}, 32'h0);
        cmp("rst error_cnt4",  -1, {28'b0, error_cnt4}, 32'h0);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Persistent wrong empty flag drives the 4-bit error counter into saturation.
        for (int i = 0; i < 20; i++) begin
            v.mrst = 1; v.cen = 1; v.wr = 0; v.rd = 0; v.din = 16'h0000;
            v.inj = 8'h40; v.chk = 1; v.code = 8'h40;
            run_vec(100 + i, v);
        end

        cmp("sat error_cnt4",   200, {28'b0, error_cnt4},   (exp_err > 15) ? 15 : exp_err);
        cmp("sat correct_cnt4", 200, {28'b0, correct_cnt4}, (exp_ok > 15) ? 15 : exp_ok);
        cmp("sat err_sticky4",  200, {24'b0, err_sticky4},  {24'b0, exp_sticky});
        cmp("sat err_code4",    200, {24'b0, err_code4},    32'h40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
